// File: rtl/controlador_stdin.sv
// Switch-based stdin for the RVSP core: halts the CPU clock on a read request
// until a debounced enter press captures the switches.
module controlador_stdin #(
    parameter int LARGURA         = 7,
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LARGURA-1:0] chaves,
    input  logic               botao_n,
    input  logic               pedido_leitura,
    output logic               halt_entrada,
    output logic [31:0]        stdin_dado,
    output logic               dado_valido,
    output logic               esperando
);

    localparam int CW = (DEBOUNCE_CICLOS > 2) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [CW-1:0] CONT_MAX = CW'(DEBOUNCE_CICLOS - 1);

    typedef enum logic [1:0] {
        OCIOSO,
        ESPERA,
        ENTREGA,
        LIBERA
    } estado_t;

    estado_t estado, proximo;

    logic          sinc_a;
    logic          pressionado_sinc;
    logic          botao_estavel;
    logic          botao_estavel_q;
    logic [CW-1:0] cont;
    logic          evento_press;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sinc_a           <= 1'b0;
            pressionado_sinc <= 1'b0;
        end else begin
            sinc_a           <= ~botao_n;
            pressionado_sinc <= sinc_a;
        end
    end

    // Level is accepted only after DEBOUNCE_CICLOS consecutive differing cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cont          <= '0;
            botao_estavel <= 1'b0;
        end else if (pressionado_sinc == botao_estavel) begin
            cont <= '0;
        end else if (cont == CONT_MAX) begin
            botao_estavel <= pressionado_sinc;
            cont          <= '0;
        end else begin
            cont <= cont + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) botao_estavel_q <= 1'b0;
        else       botao_estavel_q <= botao_estavel;
    end

    assign evento_press = botao_estavel & ~botao_estavel_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) estado <= OCIOSO;
        else       estado <= proximo;
    end

    always_comb begin
        proximo = estado;
        unique case (estado)
            OCIOSO:  if (pedido_leitura) proximo = ESPERA;
            ESPERA:  if (evento_press) proximo = ENTREGA;
            ENTREGA: proximo = LIBERA;
            LIBERA:  if (!pedido_leitura) proximo = OCIOSO;
            default: proximo = OCIOSO;
        endcase
    end

    always_comb begin
        halt_entrada = 1'b0;
        dado_valido  = 1'b0;
        unique case (estado)
            ESPERA:  halt_entrada = 1'b1;
            ENTREGA: dado_valido  = 1'b1;
            default: ;
        endcase
    end

    assign esperando = halt_entrada;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stdin_dado <= '0;
        else if (estado == ESPERA && evento_press)
            stdin_dado <= {{(32-LARGURA){1'b0}}, chaves};
    end

endmodule

// File: tb/tb_controlador_stdin.sv
// Directed bench for controlador_stdin with a short debounce window.
module tb_controlador_stdin;

    localparam int L = 7;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [L-1:0] chaves = '0;
    logic         botao_n = 1'b1;
    logic         pedido = 1'b0;
    logic         halt;
    logic [31:0]  dado;
    logic         dv;
    logic         esp;

    int checks = 0;
    int errors = 0;
    int pulses;
    int at;
    int n;
    int bad;

    controlador_stdin #(
        .LARGURA(L),
        .DEBOUNCE_CICLOS(D)
    ) dut (
        .clk(clk),
        .reset(reset),
        .chaves(chaves),
        .botao_n(botao_n),
        .pedido_leitura(pedido),
        .halt_entrada(halt),
        .stdin_dado(dado),
        .dado_valido(dv),
        .esperando(esp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dv(input int budget, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!dv && cnt < budget);
    endtask

    task automatic settle;
        botao_n = 1'b1;
        repeat (8) tick();
    endtask

    initial begin
        #12;
        check("rst_halt", halt, 0);
        check("rst_dv", dv, 0);
        check("rst_dado", dado, 0);
        check("rst_esp", esp, 0);
        reset = 1'b0;
        tick();

        // press with no request
        botao_n = 1'b0;
        pulses = 0;
        repeat (10) begin tick(); if (dv) pulses++; end
        botao_n = 1'b1;
        repeat (8) begin tick(); if (dv) pulses++; end
        check("idle_pulses", pulses, 0);
        check("idle_dado", dado, 0);

        // clean press
        chaves = 7'd42;
        pedido = 1'b1;
        tick();
        check("req_halt", halt, 1);
        check("req_esp", esp, 1);
        botao_n = 1'b0;
        bad = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (dv || !halt) bad++;
        end
        check("press_early", bad, 0);
        tick();
        check("cap_dv", dv, 1);
        check("cap_halt", halt, 0);
        check("cap_dado", dado, 42);
        check("cap_esp", esp, 0);
        tick();
        check("strobe_len", dv, 0);
        repeat (2) tick();
        pedido = 1'b0;
        settle();

        // bouncing press
        chaves = 7'd17;
        pedido = 1'b1;
        tick();
        pulses = 0;
        at = 0;
        for (int i = 1; i <= 30; i++) begin
            if (i <= 12) botao_n = (((i - 1) / 2) % 2) != 0;
            else         botao_n = 1'b0;
            tick();
            if (dv) begin pulses++; at = i; end
        end
        check("bounce_pulses", pulses, 1);
        check("bounce_at", at, 19);
        check("bounce_dado", dado, 17);
        pedido = 1'b0;
        settle();

        // button held before the request
        botao_n = 1'b0;
        repeat (8) tick();
        chaves = 7'd99;
        pedido = 1'b1;
        tick();
        pulses = 0;
        repeat (10) begin tick(); if (dv) pulses++; end
        check("held_pulses", pulses, 0);
        check("held_halt", halt, 1);
        settle();
        check("rel_halt", halt, 1);
        botao_n = 1'b0;
        wait_dv(20, n);
        check("held_lat", n, 7);
        check("held_dado", dado, 99);

        // second press while request still high
        settle();
        check("libera_halt", halt, 0);
        botao_n = 1'b0;
        pulses = 0;
        repeat (10) begin tick(); if (dv) pulses++; end
        check("libera_pulses", pulses, 0);
        check("libera_dado", dado, 99);
        botao_n = 1'b1;
        pedido = 1'b0;
        repeat (8) tick();
        chaves = 7'd5;
        pedido = 1'b1;
        tick();
        check("rereq_halt", halt, 1);
        botao_n = 1'b0;
        wait_dv(20, n);
        check("rereq_lat", n, 7);
        check("rereq_dado", dado, 5);
        pedido = 1'b0;
        tick();
        check("drop_dv", dv, 0);
        check("drop_halt", halt, 0);
        tick();
        settle();

        // asynchronous reset during the wait
        pedido = 1'b1;
        tick();
        check("pre_rst_halt", halt, 1);
        #2 reset = 1'b1;
        #1;
        check("async_halt", halt, 0);
        check("async_esp", esp, 0);
        check("async_dado", dado, 0);
        #1 reset = 1'b0;
        pedido = 1'b0;
        tick();
        botao_n = 1'b0;
        pulses = 0;
        bad = 0;
        repeat (10) begin
            tick();
            if (dv) pulses++;
            if (halt) bad++;
        end
        check("post_rst_pulses", pulses, 0);
        check("post_rst_halt", bad, 0);
        check("post_rst_dado", dado, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controlador_stdin.md
# controlador_stdin

Input-side counterpart of the 7-bit stdout/7-segment path: lets the RVSP processor read a user-entered value from the board switches. When the CPU issues a read request, the block raises a halt that freezes the processor clock, waits for a debounced press of the enter button, and captures the switch value. It then presents the value zero-extended to 32 bits with a one-cycle valid strobe, releases the halt, and waits for the CPU to drop its request. It sits beside the processor in the top level; its halt output is ORed with the CPU's own HALT before gating the fast clock.

## Interface
- LARGURA, 7: switch width, equal to the stdout value width.
- DEBOUNCE_CICLOS, 50000: consecutive stable cycles needed to accept a button level; 1 ms at 50 MHz; must be ≥ 2.
- clk  input  1  free-running fast board clock; not gated by any halt.
- reset  input  1  asynchronous, active-high; clears all state.
- chaves  input  LARGURA  raw switch value; sampled only on acceptance.
- botao_n  input  1  raw enter button, active-low, asynchronous, bouncing.
- pedido_leitura  input  1  CPU read request; level, held until the read instruction retires.
- halt_entrada  output  1  freezes the processor clock while waiting for user input.
- stdin_dado  output  32  captured value, zero-extended; holds until the next capture.
- dado_valido  output  1  one-cycle strobe marking the capture.
- esperando  output  1  user-prompt LED; equals halt_entrada.

## Operation
- Synchroniser: 2 flops on ~botao_n produce `pressionado_sinc`. Reset value 0.
- Debouncer:
  - Counter `cont` tracks cycles in which `pressionado_sinc` differs from `botao_estavel`.
  - `cont` clears whenever the two are equal.
  - When `cont` reaches DEBOUNCE_CICLOS-1 while they still differ, `botao_estavel` takes the new level and `cont` clears.
  - Counter width is clog2(DEBOUNCE_CICLOS); the counter never wraps.
- Press event: one-cycle pulse when `botao_estavel` rises 0→1. Release events generate nothing.
- FSM, registered, four states:
  - OCIOSO: halt_entrada=0. Goes to ESPERA when pedido_leitura=1.
  - ESPERA: halt_entrada=1. On a press event, stdin_dado <= {zeros, chaves} and the FSM goes to ENTREGA.
  - ENTREGA: dado_valido=1, halt_entrada=0, for exactly one cycle. Always goes to LIBERA.
  - LIBERA: halt_entrada=0. Goes to OCIOSO when pedido_leitura=0.
- Press events in OCIOSO, ENTREGA or LIBERA are discarded; stdin_dado is unchanged.
- A button already held when ESPERA is entered does not count. The user must release and press again; the edge requirement enforces this.
- If pedido_leitura drops during ESPERA, the block stays in ESPERA. The request is committed once taken.
- Reset values:
  - state OCIOSO
  - halt_entrada=0, esperando=0, dado_valido=0
  - stdin_dado=0
  - cont=0, botao_estavel=0, synchroniser flops=0

## Timing
- pedido_leitura sampled high at edge N → halt_entrada=1 after edge N (registered, one cycle latency).
- Latency from raw press, once the bounce has stopped, to ENTREGA: 2 synchroniser cycles + DEBOUNCE_CICLOS + 1 cycle.
- chaves is sampled at the same edge that enters ENTREGA.
- halt_entrada falls at the same edge that raises dado_valido. stdin_dado is already stable when the CPU clock resumes.
- Bounce shorter than DEBOUNCE_CICLOS cycles never changes `botao_estavel`.
- pedido_leitura falling while in ENTREGA: LIBERA is still visited, then OCIOSO on the next edge.
- pedido_leitura re-asserted in the same cycle that LIBERA exits: OCIOSO takes it on the following edge. No request is lost.
- Reset asserted mid-ESPERA: halt_entrada drops immediately (asynchronous), and stdin_dado clears to 0.

## Test plan
All scenarios use DEBOUNCE_CICLOS=4 and LARGURA=7.
- Reset then idle → all outputs 0. A press with pedido_leitura=0 leaves stdin_dado=0 and never pulses dado_valido.
- pedido_leitura=1, chaves=7'd42, clean press held 10 cycles → halt_entrada=1 from the cycle after the request. Press reaches ENTREGA 7 cycles after botao_n falls. stdin_dado=32'd42 with a one-cycle dado_valido, and halt_entrada=0 in that same cycle.
- Bouncing press (botao_n toggles every 2 cycles for 12 cycles, then low) with a request pending → exactly one capture, only after the final stable low.
- Button held before the request, chaves=7'd99 → no capture while held. After release and a new press, stdin_dado=32'd99.
- After a capture, keep pedido_leitura=1 and press again → ignored (state LIBERA). Drop the request, re-raise it with chaves=7'd5, press → stdin_dado=32'd5.
- Reset pulse during ESPERA → halt_entrada=0 asynchronously, before the next clock edge. After reset release the FSM is OCIOSO and a press without a request changes nothing.
